// File: rtl/ps2_scan_decoder_pkg.sv
// Shared types and constants for the PS/2 scan-code-set-2 decoder.
package ps2_pkg;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } dec_state_t;

    localparam logic [7:0] SC_EXT        = 8'hE0;
    localparam logic [7:0] SC_BREAK      = 8'hF0;
    localparam logic [7:0] SC_PAUSE      = 8'hE1;
    localparam logic [7:0] SC_PAUSE_CODE = 8'h77;

    // Bytes after E1 before the synthetic Pause make is emitted (7th byte).
    localparam logic [2:0] PAUSE_LAST = 3'd6;

    // Keyboard status/ack responses and line noise that never form key events.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF) || (b == 8'hAA) ||
               (b == 8'hFA) || (b == 8'hFE);
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Event read port: the decoder presents the FIFO head, the consumer pops it.
interface ps2_scan_decoder_if;

    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_rd;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_break,
        input  ev_rd
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_break,
        output ev_rd
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO with wrap-bit pointers and a sticky overflow flag.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_50_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  ps2_event_t               push_data,
    input  logic                     pop,
    input  logic                     ovf_clr,
    output ps2_event_t               head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    ps2_event_t      mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            empty;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push && (!full || do_pop);

    // NOTE: storage has no reset; the head is forced to zero while empty instead.
    always_ff @(posedge clk_50_i) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign head_valid = !empty;
    assign count      = wr_ptr - rd_ptr;

endmodule

// File: rtl/ps2_scan_decoder.sv
// Scan-code-set-2 prefix decoder feeding an event FIFO.
// Define PS2_DEC_TYPEMATIC_FILTER_EN to drop keyboard auto-repeat makes.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk_50_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [7:0]              scancode_i,
    ps2_scan_decoder_if.master      ev_if,
    output logic                    overflow_o,
    input  logic                    ovf_clr_i,
    output logic [$clog2(DEPTH):0]  count_o
);

    dec_state_t  state;
    logic [2:0]  pause_cnt;
    logic        valid_q;
    logic        accept;
    logic        discard;
    logic        emit;
    ps2_event_t  emit_ev;
    logic        push;
    ps2_event_t  head;

    assign accept  = valid_i && !valid_q;
    assign discard = is_discard(scancode_i);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        emit         = 1'b0;
        emit_ev.ext  = 1'b0;
        emit_ev.brk  = 1'b0;
        emit_ev.code = scancode_i;
        unique case (state)
            IDLE: begin
                emit = !discard && (scancode_i != SC_EXT) &&
                       (scancode_i != SC_BREAK) && (scancode_i != SC_PAUSE);
            end
            EXT: begin
                emit        = !discard && (scancode_i != SC_BREAK);
                emit_ev.ext = 1'b1;
            end
            BRK: begin
                emit        = !discard;
                emit_ev.brk = 1'b1;
            end
            EXT_BRK: begin
                emit        = !discard;
                emit_ev.ext = 1'b1;
                emit_ev.brk = 1'b1;
            end
            PAUSE: begin
                emit         = (pause_cnt == PAUSE_LAST);
                emit_ev.ext  = 1'b1;
                emit_ev.code = SC_PAUSE_CODE;
            end
            default: emit = 1'b0;
        endcase
        emit = emit && accept;
    end

    always_ff @(posedge clk_50_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            state     <= IDLE;
            pause_cnt <= '0;
        end else begin
            valid_q <= valid_i;
            if (accept) begin
                unique case (state)
                    IDLE: begin
                        if (discard) begin
                            state <= IDLE;
                        end else if (scancode_i == SC_EXT) begin
                            state <= EXT;
                        end else if (scancode_i == SC_BREAK) begin
                            state <= BRK;
                        end else if (scancode_i == SC_PAUSE) begin
                            state     <= PAUSE;
                            pause_cnt <= '0;
                        end
                    end
                    EXT: begin
                        state <= (!discard && scancode_i == SC_BREAK) ? EXT_BRK : IDLE;
                    end
                    BRK, EXT_BRK: begin
                        state <= IDLE;
                    end
                    // Pause's payload is consumed blindly; noise bytes are not filtered here.
                    PAUSE: begin
                        if (pause_cnt == PAUSE_LAST) begin
                            state     <= IDLE;
                            pause_cnt <= '0;
                        end else begin
                            pause_cnt <= pause_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
    logic [8:0] last_make;
    logic       held;
    logic       same_key;

    assign same_key = (last_make == {emit_ev.ext, emit_ev.code});
    assign push     = emit && !(!emit_ev.brk && held && same_key);

    always_ff @(posedge clk_50_i or posedge rst_i) begin
        if (rst_i) begin
            last_make <= '0;
            held      <= 1'b0;
        end else if (emit) begin
            if (emit_ev.brk) begin
                if (same_key) begin
                    held <= 1'b0;
                end
            end else if (!(held && same_key)) begin
                last_make <= {emit_ev.ext, emit_ev.code};
                held      <= 1'b1;
            end
        end
    end
`else
    assign push = emit;
`endif

    ps2_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_50_i   (clk_50_i),
        .rst_i      (rst_i),
        .push       (push),
        .push_data  (emit_ev),
        .pop        (ev_if.ev_rd),
        .ovf_clr    (ovf_clr_i),
        .head       (head),
        .head_valid (ev_if.ev_valid),
        .count      (count_o),
        .overflow   (overflow_o)
    );

    assign ev_if.ev_code  = head.code;
    assign ev_if.ev_ext   = head.ext;
    assign ev_if.ev_break = head.brk;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: byte-stream reference model plus decoupled event monitor.
module tb_ps2_scan_decoder;
    import ps2_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic [7:0]    sc = 8'h00;
    logic          ovf_clr = 1'b0;
    logic          overflow;
    logic [CW-1:0] count;

    ps2_scan_decoder_if ev_if ();

    ps2_scan_decoder #(.DEPTH(DEPTH)) dut (
        .clk_50_i   (clk),
        .rst_i      (rst),
        .valid_i    (valid),
        .scancode_i (sc),
        .ev_if      (ev_if),
        .overflow_o (overflow),
        .ovf_clr_i  (ovf_clr),
        .count_o    (count)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: prefix bytes collected as a string, events derived from it.
    ps2_event_t exp_q[$];
    logic [7:0] pend[$];
    logic       exp_ovf = 1'b0;
    logic [8:0] last_make = '0;
    bit         held = 1'b0;

    function automatic bit is_noise(input logic [7:0] b);
        return b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        exp_ovf   = 1'b0;
        held      = 1'b0;
        last_make = '0;
    endtask

    task automatic model_event(input bit ext, input bit brk, input logic [7:0] code, input bit pop_now);
        ps2_event_t e;
        e.ext  = ext;
        e.brk  = brk;
        e.code = code;
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
        if (!brk) begin
            if (held && last_make == {ext, code}) return;
            last_make = {ext, code};
            held      = 1'b1;
        end else if (last_make == {ext, code}) begin
            held = 1'b0;
        end
`endif
        if (exp_q.size() >= DEPTH && !pop_now) exp_ovf = 1'b1;
        else exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit pop_now);
        bit ext;
        bit brk;
        if (pend.size() > 0 && pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) begin
                pend.delete();
                model_event(1'b1, 1'b0, 8'h77, pop_now);
            end
            return;
        end
        if (is_noise(b)) begin
            pend.delete();
            return;
        end
        if ((pend.size() == 0 && b inside {8'hE0, 8'hF0, 8'hE1}) ||
            (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0)) begin
            pend.push_back(b);
            return;
        end
        ext = 1'b0;
        brk = 1'b0;
        foreach (pend[i]) begin
            if (pend[i] == 8'hE0) ext = 1'b1;
            if (pend[i] == 8'hF0) brk = 1'b1;
        end
        pend.delete();
        model_event(ext, brk, b, pop_now);
    endtask

    // Monitor: owns ev_rd, pops the scoreboard whenever the DUT pops.
    bit   auto_rd = 1'b0;
    bit   manual_rd = 1'b0;
    logic rd_now;

    initial begin
        ps2_event_t e;
        ev_if.ev_rd = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            rd_now = auto_rd ? ($urandom_range(0, 3) != 0) : manual_rd;
            if (rd_now && ev_if.ev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL ev_unexpected: got ext=%0b brk=%0b code=0x%0h expected no event",
                             ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_head", int'({ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}),
                          int'({e.ext, e.brk, e.code}));
                end
            end
            ev_if.ev_rd = rd_now;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(negedge clk);
        valid = 1'b1;
        sc    = b;
        model_byte(b, 1'b0);
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int budget;
        auto_rd = 1'b1;
        budget  = 400;
        repeat (2) @(negedge clk);
        while ((exp_q.size() != 0 || ev_if.ev_valid) && budget > 0) begin
            @(negedge clk);
            #2;
            budget--;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        check({name, "_drain_valid"}, int'(ev_if.ev_valid), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, int'(ev_if.ev_valid), 0);
        check({name, "_code"}, int'(ev_if.ev_code), 0);
        check({name, "_ext"}, int'(ev_if.ev_ext), 0);
        check({name, "_brk"}, int'(ev_if.ev_break), 0);
        check({name, "_ovf"}, int'(overflow), 0);
        check({name, "_count"}, int'(count), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pool [14] = '{8'h1C, 8'h75, 8'h14, 8'h77, 8'hE0, 8'hE0, 8'hF0,
                                  8'hF0, 8'hE1, 8'hFA, 8'h00, 8'hAA, 8'h5A, 8'h29};
        logic [7:0] tm_seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        logic [7:0] b;
        int budget;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Make then break of the same key, held in the FIFO.
        send_byte(8'h1C, 1, 1);
        send_byte(8'hF0, 1, 1);
        send_byte(8'h1C, 1, 1);
        check("two_ev_count", int'(count), 2);
        drain("basic");

        // Extended make/break with valid held for 500 cycles per byte.
        auto_rd = 1'b0;
        send_byte(8'hE0, 500, 1);
        send_byte(8'h75, 500, 1);
        send_byte(8'hE0, 500, 1);
        send_byte(8'hF0, 500, 1);
        send_byte(8'h75, 500, 1);
        check("long_hold_count", int'(count), 2);
        drain("ext");

        foreach (pause_seq[i]) send_byte(pause_seq[i], 1, 1);
        send_byte(8'h1C, 1, 1);
        drain("pause");

        // Fill past capacity, then clear, then pop+push at full.
        auto_rd   = 1'b0;
        manual_rd = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h10 + 8'(i), 1, 0);
        @(negedge clk);
        check("full_count", int'(count), DEPTH);
        check("full_ovf", int'(overflow), int'(exp_ovf));
        check("full_head", int'(ev_if.ev_code), int'(exp_q[0].code));
        @(negedge clk);
        ovf_clr = 1'b1;
        exp_ovf = 1'b0;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clear", int'(overflow), int'(exp_ovf));
        @(negedge clk);
        manual_rd = 1'b1;
        valid     = 1'b1;
        sc        = 8'h30;
        model_byte(8'h30, 1'b1);
        @(negedge clk);
        manual_rd = 1'b0;
        valid     = 1'b0;
        @(negedge clk);
        check("poppush_count", int'(count), DEPTH);
        check("poppush_ovf", int'(overflow), int'(exp_ovf));
        // Overflow set and clear in the same cycle: set wins.
        @(negedge clk);
        valid   = 1'b1;
        sc      = 8'h31;
        ovf_clr = 1'b1;
        model_byte(8'h31, 1'b0);
        @(negedge clk);
        valid   = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clk);
        check("set_beats_clr", int'(overflow), int'(exp_ovf));
        ovf_clr = 1'b1;
        exp_ovf = 1'b0;
        @(negedge clk);
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clear2", int'(overflow), int'(exp_ovf));
        drain("full");

        // Reset after a prefix byte, then decoding restarts in IDLE.
        send_byte(8'hE0, 1, 1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        send_byte(8'h75, 1, 1);
        send_byte(8'hE0, 1, 1);
        send_byte(8'hFA, 1, 1);
        send_byte(8'h1C, 1, 1);
        drain("after_rst");

        // Byte held through reset release is accepted exactly once.
        @(negedge clk);
        valid = 1'b1;
        sc    = 8'h5A;
        rst   = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_byte(8'h5A, 1'b0);
        repeat (5) @(negedge clk);
        valid = 1'b0;
        drain("held_rst");

        // Typematic repeat sequence.
        do_reset();
        auto_rd = 1'b0;
        foreach (tm_seq[i]) send_byte(tm_seq[i], 1, 1);
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
        check("typematic_count", int'(count), 3);
`else
        check("typematic_count", int'(count), 5);
`endif
        drain("typematic");

        // Randomised byte stream with random reads.
        auto_rd = 1'b1;
        for (int n = 0; n < 300; n++) begin
            budget = 200;
            while (exp_q.size() >= DEPTH - 2 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) check("rand_stall", exp_q.size(), DEPTH - 3);
            b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
            send_byte(b, $urandom_range(1, 3), $urandom_range(0, 2));
        end
        // Flush any pending Pause payload with neutral bytes.
        repeat (8) send_byte(8'h1C, 1, 1);
        drain("random");
        check("final_ovf", int'(overflow), int'(exp_ovf));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Downstream consumer of the PS/2 keyboard receiver: takes raw scan-code-set-2 bytes, strips the E0/F0/E1 prefixes into a per-key event (code, extended, break), and buffers events in a show-ahead FIFO. The CPU-side peripheral reads the FIFO. The block runs in the 50 MHz domain and holds no PS/2-clock logic.

## Interface
- DEPTH, 8: FIFO depth in events; power of two, ≥2.
- clk_50_i  in  1  system clock, 50 MHz.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  receiver byte-valid level; may stay high for many clk cycles per byte.
- scancode_i  in  8  receiver byte; stable while valid_i=1.
- ev_valid_o  out  1  FIFO non-empty; reset 0.
- ev_code_o  out  8  head event key code; reset 8'h00.
- ev_ext_o  out  1  head event was E0-prefixed; reset 0.
- ev_break_o  out  1  head event is a key release; reset 0.
- ev_rd_i  in  1  pop head event this cycle.
- overflow_o  out  1  sticky, set when an event is dropped on full; reset 0.
- ovf_clr_i  in  1  clears overflow_o.
- count_o  out  $clog2(DEPTH)+1  events held; reset 0.

## Operation
- Byte acceptance: register valid_q <= valid_i. A byte is accepted at an edge where valid_i=1 and valid_q=0. Later high cycles are ignored.
- FSM states and transitions on each accepted byte b:
  - IDLE: E0→EXT, F0→BRK, E1→PAUSE (cnt=0); otherwise emit {ext=0,brk=0,b}.
  - EXT: F0→EXT_BRK; otherwise emit {1,0,b}, →IDLE.
  - BRK: emit {0,1,b}, →IDLE.
  - EXT_BRK: emit {1,1,b}, →IDLE.
  - PAUSE: cnt++. When cnt reaches 6 (7th byte after E1), emit {1,0,8'h77} and →IDLE.
- Discard bytes 00, FF, AA, FA, FE in every state except PAUSE. Return to IDLE with no event.
- FIFO push/pop rules:
  - Push on emit. Pop on ev_rd_i && ev_valid_o. ev_rd_i while empty is ignored.
  - Push while full and no pop: event dropped, overflow_o<=1.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: the push completes and the pop is ignored.
- overflow_o: ovf_clr_i clears it. If a set and a clear occur in the same cycle, set wins.
- Pointers are DEPTH-modulo with one extra wrap bit. full = MSBs differ and the rest are equal.
- Reset mid-sequence: FSM→IDLE, FIFO emptied, valid_q=0. If valid_i is still high after reset release, that byte is accepted once.

## Timing
- Valid_i first sampled high at edge k → event written at edge k → ev_valid_o/ev_* valid from cycle k+1.
- Pop at edge k → next head, or ev_valid_o=0, from cycle k+1.
- Prefix bytes cost one accepted byte each and produce no output.
- Minimum 2 clk between accepted bytes (valid_i must return low).

## Configuration
- PS2_DEC_TYPEMATIC_FILTER_EN defined: filter keyboard auto-repeat.
  - Hold last_make {ext,code} plus a held flag.
  - A make event equal to last_make with held=1 is discarded.
  - Any break event with the same {ext,code} clears held.
  - Any other make replaces last_make and sets held.
  - Reset clears held.
- Undefined: every make event is pushed, repeats included.

## Structure
- Package ps2_pkg:
  - ps2_event_t packed struct {ext, brk, code[7:0]}.
  - FSM enum {IDLE, EXT, BRK, EXT_BRK, PAUSE}.
  - Constants SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_PAUSE=8'hE1, SC_PAUSE_CODE=8'h77.
- Sub-module ps2_event_fifo:
  - Parameterised by DEPTH, carrying ps2_event_t, show-ahead.
  - Owns pointers, count, full/empty and overflow.
- The top holds the edge detect, FSM and typematic filter.

## Test plan
- Bytes 1C; F0,1C → events {0,0,1C} then {0,1,1C}; count_o=2.
- E0,75; E0,F0,75 → {1,0,75}, {1,1,75}. Hold valid_i high 500 cycles per byte → still exactly 2 events.
- E1,14,77,E1,F0,14,F0,77 → single event {1,0,77}, FSM back in IDLE. Next byte 1C → {0,0,1C}.
- DEPTH=8: push 9 makes with no reads → count_o=8, overflow_o=1, head is the first code. Pop + push in one cycle at full → count 8, no new overflow. ovf_clr_i → overflow_o=0.
- Assert rst_i after E0 → outputs reset. Then byte 75 → {0,0,75}. Byte FA in EXT → discarded, IDLE.
- Build with PS2_DEC_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C,1C → {0,0,1C},{0,1,1C},{0,0,1C}. Without the macro → 5 events.
